// File: rtl/rast_pkg.sv
// Shared rasterizer definitions for the sample iterator slice.
//   Sizing : SIGFIG position/colour width, RADIX fraction bits (>= 3),
//            VERTS x AXIS triangle, COLORS channels, SAMPS lanes per group.
//   Types  : fixed-point word, triangle/colour/box/sample bundles, FSM state.
//   Helper : step_from_subsample() turns the one-hot subsample code into a step.
package rast_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;

  // box_t first index
  localparam int LL = 0;
  localparam int UR = 1;

  typedef logic [SIGFIG-1:0]               fix_t;
  typedef fix_t [VERTS-1:0][AXIS-1:0]      tri_t;
  typedef fix_t [COLORS-1:0]               color_t;
  typedef fix_t [1:0][1:0]                 box_t;   // [LL/UR][x/y]
  typedef fix_t [1:0][SAMPS-1:0]           samp_t;  // [x/y][lane]
  typedef logic [SAMPS-1:0]                lane_vld_t;

  // state | meaning
  // WAIT  | idle, upstream may present a triangle
  // TEST  | walking the box, one sample group per unstalled cycle
  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } iter_state_t;

  // 1000 -> 1.0 px, 0100 -> 0.5 px, ... with RADIX fraction bits.
  function automatic fix_t step_from_subsample(input logic [3:0] sub);
    return fix_t'(sub) << (RADIX - 3);
  endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// Bundle of the iterator's upstream (R13) and downstream (R14) signals.
//   slave  : the iterator (takes triangle/box/halt in, drives samples out)
//   master : the neighbouring stages (drive triangle/box/halt, take samples)
// Optional counters exist only when SAMPLE_ITER_STATS_EN is defined.
interface sample_iterator_if;
  import rast_pkg::*;

  tri_t      tri_R13S;
  color_t    color_R13U;
  box_t      box_R13S;
  logic      validTri_R13H;
  logic [3:0] subSample_RnnnnU;
  logic      halt_RnnnnL;

  logic      halt_R13L;
  tri_t      tri_R14S;
  color_t    color_R14U;
  samp_t     sample_R14S;
  lane_vld_t validSamp_R14H;
`ifdef SAMPLE_ITER_STATS_EN
  logic [31:0] samp_count_R14U;
  logic [31:0] tri_count_R14U;
`endif

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnL,
    output halt_R13L, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SAMPLE_ITER_STATS_EN
    , output samp_count_R14U, tri_count_R14U
`endif
  );

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnL,
    input  halt_R13L, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SAMPLE_ITER_STATS_EN
    , input samp_count_R14U, tri_count_R14U
`endif
  );

endinterface

// File: rtl/sample_iterator_samp_row_gen.sv
// samp_row_gen: combinational lane generator for one horizontal sample group.
//   cur_x_i/cur_y_i : position of lane 0
//   step_i          : subsample step (unsigned)
//   ur_x_i/ur_y_i   : upper-right corner of the box
//   lane_x_o        : x of each lane (lane s = cur_x + s*step)
//   lane_vld_o      : lane lies inside the box
//   next_x_o        : cur_x + SAMPS*step
//   row_end_o       : next group would start beyond ur.x
module samp_row_gen
  import rast_pkg::*;
(
  input  fix_t             cur_x_i,
  input  fix_t             cur_y_i,
  input  fix_t             step_i,
  input  fix_t             ur_x_i,
  input  fix_t             ur_y_i,
  output fix_t [SAMPS-1:0] lane_x_o,
  output lane_vld_t        lane_vld_o,
  output fix_t             next_x_o,
  output logic             row_end_o
);

  // One extra bit so a sum running past the top of the range compares as
  // "beyond the box" instead of wrapping negative.
  typedef logic signed [SIGFIG:0] ext_t;

  ext_t acc;
  ext_t ur_x_e;
  ext_t step_e;
  logic y_in;

  always_comb begin
    ur_x_e     = {ur_x_i[SIGFIG-1], ur_x_i};
    step_e     = {1'b0, step_i};
    y_in       = $signed(cur_y_i) <= $signed(ur_y_i);
    acc        = {cur_x_i[SIGFIG-1], cur_x_i};
    lane_x_o   = '0;
    lane_vld_o = '0;
    for (int s = 0; s < SAMPS; s++) begin
      lane_x_o[s]   = acc[SIGFIG-1:0];
      lane_vld_o[s] = y_in && (acc <= ur_x_e);
      acc           = acc + step_e;
    end
    next_x_o  = acc[SIGFIG-1:0];
    row_end_o = !(acc <= ur_x_e);
  end

endmodule

// File: rtl/sample_iterator.sv
// sample_iterator: walks a triangle's bounding box in subsample steps and
// emits SAMPS sample positions per cycle toward the sample-test stage.
//   clk : clock
//   rst : asynchronous reset, active low
//   bus : sample_iterator_if.slave (R13 triangle/box in, R14 samples out,
//         halt_RnnnnL downstream stall in, halt_R13L upstream stall out)
// Build option SAMPLE_ITER_STATS_EN adds saturating sample/triangle counters.
module sample_iterator
  import rast_pkg::*;
(
  input logic              clk,
  input logic              rst,
  sample_iterator_if.slave bus
);

  iter_state_t state_q;
  logic        last_q;     // the group now on R14 is the final one
  tri_t        tri_q;
  color_t      color_q;
  fix_t        ll_x_q, ur_x_q, ur_y_q;
  fix_t        step_q;
  fix_t        cur_x_q, cur_y_q;
  samp_t       samp_q;
  lane_vld_t   vld_q;

  fix_t             g_x, g_y, g_step, g_ll_x, g_ur_x, g_ur_y;
  fix_t [SAMPS-1:0] lane_x;
  lane_vld_t        lane_vld;
  fix_t             next_x;
  logic             row_end;

  logic signed [SIGFIG:0] next_y_e, ur_y_e;
  logic  col_more;
  fix_t  cur_x_d, cur_y_d;
  logic  last_d;
  samp_t samp_d;

  // On acceptance the first group is built straight from the R13 inputs so
  // it reaches R14 one cycle after the triangle is taken.
  always_comb begin
    if (state_q == WAIT) begin
      g_x    = bus.box_R13S[LL][0];
      g_y    = bus.box_R13S[LL][1];
      g_ll_x = bus.box_R13S[LL][0];
      g_ur_x = bus.box_R13S[UR][0];
      g_ur_y = bus.box_R13S[UR][1];
      g_step = step_from_subsample(bus.subSample_RnnnnU);
    end else begin
      g_x    = cur_x_q;
      g_y    = cur_y_q;
      g_ll_x = ll_x_q;
      g_ur_x = ur_x_q;
      g_ur_y = ur_y_q;
      g_step = step_q;
    end
  end

  samp_row_gen u_row_gen (
    .cur_x_i    (g_x),
    .cur_y_i    (g_y),
    .step_i     (g_step),
    .ur_x_i     (g_ur_x),
    .ur_y_i     (g_ur_y),
    .lane_x_o   (lane_x),
    .lane_vld_o (lane_vld),
    .next_x_o   (next_x),
    .row_end_o  (row_end)
  );

  // Moving to a new row needs an in-box lane 0 on this row; an inverted box
  // therefore ends after a single all-invalid group instead of stepping rows.
  always_comb begin
    next_y_e = {g_y[SIGFIG-1], g_y} + {1'b0, g_step};
    ur_y_e   = {g_ur_y[SIGFIG-1], g_ur_y};
    col_more = lane_vld[0] && (next_y_e <= ur_y_e);
    cur_x_d  = next_x;
    cur_y_d  = g_y;
    last_d   = 1'b0;
    if (row_end) begin
      if (col_more) begin
        cur_x_d = g_ll_x;
        cur_y_d = next_y_e[SIGFIG-1:0];
      end else begin
        last_d = 1'b1;
      end
    end
    samp_d = '0;
    for (int s = 0; s < SAMPS; s++) begin
      samp_d[0][s] = lane_x[s];
      samp_d[1][s] = g_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      last_q  <= 1'b0;
      tri_q   <= '0;
      color_q <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      samp_q  <= '0;
      vld_q   <= '0;
    end else if (bus.halt_RnnnnL) begin
      case (state_q)
        WAIT: begin
          if (bus.validTri_R13H) begin
            tri_q   <= bus.tri_R13S;
            color_q <= bus.color_R13U;
            ll_x_q  <= g_ll_x;
            ur_x_q  <= g_ur_x;
            ur_y_q  <= g_ur_y;
            step_q  <= g_step;
            samp_q  <= samp_d;
            vld_q   <= lane_vld;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            last_q  <= last_d;
            state_q <= TEST;
          end
        end
        TEST: begin
          if (last_q) begin
            vld_q   <= '0;
            last_q  <= 1'b0;
            state_q <= WAIT;
          end else begin
            samp_q  <= samp_d;
            vld_q   <= lane_vld;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            last_q  <= last_d;
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end

  assign bus.halt_R13L      = (state_q == WAIT) && bus.halt_RnnnnL;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = samp_q;
  assign bus.validSamp_R14H = vld_q;

`ifdef SAMPLE_ITER_STATS_EN
  logic [31:0] samp_cnt_q, tri_cnt_q;
  logic [32:0] samp_sum;

  // Every unstalled TEST cycle hands the R14 group downstream.
  assign samp_sum = {1'b0, samp_cnt_q} + 33'($countones(vld_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt_q <= '0;
      tri_cnt_q  <= '0;
    end else if (bus.halt_RnnnnL) begin
      if (state_q == TEST) begin
        samp_cnt_q <= samp_sum[32] ? '1 : samp_sum[31:0];
      end
      if (state_q == WAIT && bus.validTri_R13H && tri_cnt_q != '1) begin
        tri_cnt_q <= tri_cnt_q + 32'd1;
      end
    end
  end

  assign bus.samp_count_R14U = samp_cnt_q;
  assign bus.tri_count_R14U  = tri_cnt_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: box walks, degenerate and inverted
// boxes, downstream stalls, back-to-back triangles and reset mid-walk.
module tb_sample_iterator;
  import rast_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_iterator_if bus();

  sample_iterator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  tri_t   exp_tri;
  color_t exp_col;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tri(input fix_t llx, input fix_t lly, input fix_t urx, input fix_t ury,
                           input logic [3:0] ss, input int seed);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        exp_tri[v][a] = fix_t'(seed * 16 + v * 4 + a);
    for (int c = 0; c < COLORS; c++)
      exp_col[c] = fix_t'(seed * 256 + c);
    bus.tri_R13S         = exp_tri;
    bus.color_R13U       = exp_col;
    bus.box_R13S[LL][0]  = llx;
    bus.box_R13S[LL][1]  = lly;
    bus.box_R13S[UR][0]  = urx;
    bus.box_R13S[UR][1]  = ury;
    bus.subSample_RnnnnU = ss;
    bus.validTri_R13H    = 1'b1;
  endtask

  // Expected lane s x = x0 + s*step (wrapped to SIGFIG bits), all lanes share y.
  task automatic check_group(input string tag, input logic [3:0] vld, input int x0,
                             input int y, input int step);
    expect_eq({tag, "_vld"}, bus.validSamp_R14H, vld);
    expect_eq({tag, "_halt"}, bus.halt_R13L, 1'b0);
    for (int s = 0; s < SAMPS; s++) begin
      expect_eq($sformatf("%s_x%0d", tag, s), bus.sample_R14S[0][s], fix_t'(x0 + s * step));
      expect_eq($sformatf("%s_y%0d", tag, s), bus.sample_R14S[1][s], fix_t'(y));
    end
  endtask

  task automatic check_idle(input string tag);
    expect_eq({tag, "_vld"}, bus.validSamp_R14H, 4'b0000);
    expect_eq({tag, "_halt"}, bus.halt_R13L, 1'b1);
  endtask

  initial begin
    rst                  = 1'b0;
    bus.halt_RnnnnL      = 1'b1;
    bus.validTri_R13H    = 1'b0;
    bus.tri_R13S         = '0;
    bus.color_R13U       = '0;
    bus.box_R13S         = '0;
    bus.subSample_RnnnnU = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    expect_eq("reset_tri", |bus.tri_R14S, 1'b0);
    expect_eq("reset_col", |bus.color_R14U, 1'b0);
    expect_eq("reset_samp", |bus.sample_R14S, 1'b0);
    rst = 1'b1;
    tick();

    // Box (0,0)-(1024,512), half-pixel step: two rows of three samples.
    drive_tri(0, 0, 1024, 512, 4'b0100, 1);
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s1g1", 4'b0111, 0, 0, 512);
    expect_eq("s1_tri", bus.tri_R14S == exp_tri, 1'b1);
    expect_eq("s1_col", bus.color_R14U == exp_col, 1'b1);
    tick();
    check_group("s1g2", 4'b0111, 0, 512, 512);
    tick();
    check_idle("s1_end");
`ifdef SAMPLE_ITER_STATS_EN
    expect_eq("s1_samp_count", bus.samp_count_R14U, 32'd6);
    expect_eq("s1_tri_count", bus.tri_count_R14U, 32'd1);
`endif

    // Degenerate box: one group, lane 0 only.
    drive_tri(2048, 2048, 2048, 2048, 4'b1000, 2);
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s2", 4'b0001, 2048, 2048, 1024);
    tick();
    check_idle("s2_end");

    // Stall while idle blocks acceptance; stall mid-walk freezes the group.
    drive_tri(0, 0, 4096, 1024, 4'b1000, 3);
    bus.halt_RnnnnL = 1'b0;
    #1;
    expect_eq("s3_wait_halt", bus.halt_R13L, 1'b0);
    tick();
    expect_eq("s3_wait_vld", bus.validSamp_R14H, 4'b0000);
    bus.halt_RnnnnL = 1'b1;
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s3g1", 4'b1111, 0, 0, 1024);
    bus.halt_RnnnnL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_group($sformatf("s3hold%0d", i), 4'b1111, 0, 0, 1024);
    end
    bus.halt_RnnnnL = 1'b1;
    tick();
    check_group("s3g2", 4'b0001, 4096, 0, 1024);
    tick();
    check_group("s3g3", 4'b1111, 0, 1024, 1024);
    tick();
    check_group("s3g4", 4'b0001, 4096, 1024, 1024);
    tick();
    check_idle("s3_end");

    // Second triangle held valid during the first walk; taken after one bubble.
    drive_tri(0, 0, 1024, 512, 4'b0100, 4);
    tick();
    check_group("s4a_g1", 4'b0111, 0, 0, 512);
    expect_eq("s4a_tri", bus.tri_R14S == exp_tri, 1'b1);
    drive_tri(fix_t'(-2048), 0, fix_t'(-1024), 0, 4'b1000, 5);
    tick();
    check_group("s4a_g2", 4'b0111, 0, 512, 512);
    tick();
    check_idle("s4_bubble");
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s4b", 4'b0011, -2048, 0, 1024);
    expect_eq("s4b_tri", bus.tri_R14S == exp_tri, 1'b1);
    tick();
    check_idle("s4_end");

    // Inverted box in x: single all-invalid group, then idle.
    drive_tri(1024, 0, 0, 1024, 4'b1000, 6);
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s5", 4'b0000, 1024, 0, 1024);
    tick();
    check_idle("s5_end");

    // Reset mid-walk drops the triangle; next one walks from its own corner.
    drive_tri(0, 0, 4096, 1024, 4'b1000, 7);
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s6g1", 4'b1111, 0, 0, 1024);
    #2;
    rst = 1'b0;
    #1;
    check_idle("s6_rst");
    expect_eq("s6_rst_tri", |bus.tri_R14S, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_tri(512, 256, 1024, 256, 4'b0010, 8);
    tick();
    bus.validTri_R13H = 1'b0;
    check_group("s6_new", 4'b0111, 512, 256, 256);
    tick();
    check_idle("s6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
